// File: rtl/nn_udiv_50ns_6ns_44_seq.sv
// Radix-2 restoring divider: 50-bit dividend / 6-bit divisor, one quotient bit per cycle.
// Flags divide-by-zero and quotients that overflow the 44-bit output.
module nn_udiv_50ns_6ns_44_seq #(
  parameter int din0_WIDTH = 50,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 44
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero,
  output logic                  quot_ovf
);

  // state | meaning
  // IDLE  | waiting for ap_start
  // CALC  | iterating, one quotient bit per edge
  // DONE  | results valid, ap_done pulse
  localparam int CW = $clog2(din0_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state, state_nxt;
  logic [din0_WIDTH-1:0]   dividend;
  logic [din0_WIDTH-1:0]   quot_acc;
  logic [din1_WIDTH-1:0]   divisor;
  logic [din1_WIDTH-1:0]   prem;
  logic [CW-1:0]           cnt;

  logic                    accept;
  logic                    last;
  logic [din1_WIDTH:0]     shifted;
  logic [din1_WIDTH-1:0]   diff;
  logic                    ge;
  logic [din1_WIDTH-1:0]   prem_nxt;
  logic [din0_WIDTH-1:0]   quot_nxt;

  // The shifted partial remainder is din1_WIDTH+1 bits wide; after a restoring
  // step it is always below the divisor, so only din1_WIDTH bits are stored.
  always_comb begin
    accept   = ap_start && (state == IDLE || state == DONE);
    last     = (state == CALC) && (cnt == '0);
    shifted  = {prem, dividend[din0_WIDTH-1]};
    ge       = shifted >= {1'b0, divisor};
    diff     = shifted[din1_WIDTH-1:0] - divisor;
    prem_nxt = ge ? diff : shifted[din1_WIDTH-1:0];
    quot_nxt = {quot_acc[din0_WIDTH-2:0], ge};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  assign ap_ready = (state != CALC);
  assign ap_done  = (state == DONE);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dividend <= '0;
      divisor  <= '0;
      quot_acc <= '0;
      prem     <= '0;
      cnt      <= '0;
    end else if (accept) begin
      dividend <= din0;
      divisor  <= din1;
      quot_acc <= '0;
      prem     <= '0;
      cnt      <= CW'(din0_WIDTH - 1);
    end else if (state == CALC) begin
      dividend <= dividend << 1;
      quot_acc <= quot_nxt;
      prem     <= prem_nxt;
      cnt      <= cnt - CW'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      quot_ovf    <= 1'b0;
    end else if (last) begin
      if (divisor == '0) begin
        quot        <= '1;
        rem         <= '0;
        div_by_zero <= 1'b1;
        quot_ovf    <= 1'b0;
      end else begin
        quot        <= quot_nxt[dout_WIDTH-1:0];
        rem         <= prem_nxt;
        div_by_zero <= 1'b0;
        quot_ovf    <= |quot_nxt[din0_WIDTH-1:dout_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_nn_udiv_50ns_6ns_44_seq.sv
// Bench for nn_udiv_50ns_6ns_44_seq: arithmetic reference model with a per-cycle compare
// process, plus literal expectations for each directed operation.
module tb_nn_udiv_50ns_6ns_44_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_ready, ap_done;
  logic [49:0] din0 = '0;
  logic [5:0]  din1 = '0;
  logic [43:0] quot;
  logic [5:0]  rem;
  logic        div_by_zero, quot_ovf;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          acc;
    int          done;
    logic [43:0] q;
    logic [5:0]  r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  exp_t held = '{default: 0};
  logic exp_done, exp_ready;

  nn_udiv_50ns_6ns_44_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .din0        (din0),
    .din1        (din1),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero),
    .quot_ovf    (quot_ovf)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Results appear 50 edges after the accepting edge.
  function automatic exp_t model(input int acc, input logic [49:0] a, input logic [5:0] b);
    exp_t e;
    longint unsigned q;
    e.acc  = acc;
    e.done = acc + 50;
    if (b == 6'd0) begin
      e.q = '1; e.r = '0; e.dz = 1'b1; e.ov = 1'b0;
    end else begin
      q    = 64'(a) / 64'(b);
      e.q  = q[43:0];
      e.r  = 6'(64'(a) % 64'(b));
      e.dz = 1'b0;
      e.ov = (q >> 44) != 0;
    end
    return e;
  endfunction

  always @(negedge ap_clk) begin
    exp_done = 1'b0;
    if (sb.size() > 0 && sb[0].done == cyc) begin
      exp_done = 1'b1;
      held = sb[0];
      void'(sb.pop_front());
    end
    exp_ready = !(sb.size() > 0 && cyc >= sb[0].acc && cyc < sb[0].done);
    chk("ap_done", 64'(ap_done), 64'(exp_done));
    chk("ap_ready", 64'(ap_ready), 64'(exp_ready));
    chk("quot", 64'(quot), 64'(held.q));
    chk("rem", 64'(rem), 64'(held.r));
    chk("div_by_zero", 64'(div_by_zero), 64'(held.dz));
    chk("quot_ovf", 64'(quot_ovf), 64'(held.ov));
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge ap_clk);
  endtask

  task automatic chk_lit(input string tag, input exp_t e, input logic [43:0] lq,
                         input logic [5:0] lr, input logic ldz, input logic lov);
    chk({tag, "_model_q"}, 64'(e.q), 64'(lq));
    chk({tag, "_model_r"}, 64'(e.r), 64'(lr));
    chk({tag, "_quot"}, 64'(quot), 64'(lq));
    chk({tag, "_rem"}, 64'(rem), 64'(lr));
    chk({tag, "_dz"}, 64'(div_by_zero), 64'(ldz));
    chk({tag, "_ovf"}, 64'(quot_ovf), 64'(lov));
    chk({tag, "_done"}, 64'(ap_done), 64'd1);
  endtask

  // Single pulse, then a stray pulse with different operands mid-CALC.
  task automatic run_op(input string tag, input logic [49:0] a, input logic [5:0] b,
                        input logic [43:0] lq, input logic [5:0] lr, input logic ldz,
                        input logic lov);
    exp_t e;
    @(negedge ap_clk);
    din0 = a; din1 = b; ap_start = 1'b1;
    e = model(cyc + 1, a, b);
    sb.push_back(e);
    @(negedge ap_clk);
    ap_start = 1'b0;
    wait_until(e.acc + 10);
    din0 = ~a; din1 = b + 6'd1; ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0; din0 = 50'd777;
    wait_until(e.done);
    chk_lit(tag, e, lq, lr, ldz, lov);
    @(negedge ap_clk);
  endtask

  initial begin
    exp_t e1, e2;
    repeat (2) @(negedge ap_clk);
    chk("rst_quot", 64'(quot), 64'd0);
    chk("rst_rem", 64'(rem), 64'd0);
    chk("rst_ready", 64'(ap_ready), 64'd1);
    chk("rst_done", 64'(ap_done), 64'd0);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);

    run_op("basic", 50'd1000, 6'd7, 44'd142, 6'd6, 1'b0, 1'b0);
    run_op("ovf", 50'h3_FFFF_FFFF_FFFF, 6'd63, 44'd279241048324, 6'd3, 1'b0, 1'b1);
    run_op("maxq", 50'd1108307720798145, 6'd63, 44'd17592186044415, 6'd0, 1'b0, 1'b0);
    run_op("dz", 50'd12345, 6'd0, 44'hFFF_FFFF_FFFF, 6'd0, 1'b1, 1'b0);

    // Back-to-back with ap_start held high; operands change during CALC.
    @(negedge ap_clk);
    din0 = 50'd100; din1 = 6'd3; ap_start = 1'b1;
    e1 = model(cyc + 1, 50'd100, 6'd3);
    e2 = model(e1.done + 1, 50'd99, 6'd9);
    sb.push_back(e1);
    sb.push_back(e2);
    wait_until(e1.acc);
    din0 = 50'd99; din1 = 6'd9;
    wait_until(e1.done);
    chk_lit("b2b1", e1, 44'd33, 6'd1, 1'b0, 1'b0);
    wait_until(e2.acc);
    ap_start = 1'b0; din0 = 50'd7; din1 = 6'd2;
    wait_until(e2.done);
    chk_lit("b2b2", e2, 44'd11, 6'd0, 1'b0, 1'b0);
    @(negedge ap_clk);

    // Reset during iteration 20.
    @(negedge ap_clk);
    din0 = 50'd5000; din1 = 6'd7; ap_start = 1'b1;
    e1 = model(cyc + 1, 50'd5000, 6'd7);
    sb.push_back(e1);
    @(negedge ap_clk);
    ap_start = 1'b0;
    wait_until(e1.acc + 20);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("abort_quot", 64'(quot), 64'd0);
    chk("abort_rem", 64'(rem), 64'd0);
    chk("abort_flags", 64'({div_by_zero, quot_ovf}), 64'd0);
    chk("abort_ready", 64'(ap_ready), 64'd1);
    chk("abort_done", 64'(ap_done), 64'd0);
    sb.delete();
    held = '{default: 0};
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (60) @(negedge ap_clk);
    run_op("post_rst", 50'd81, 6'd9, 44'd9, 6'd0, 1'b0, 1'b0);

    repeat (3) @(negedge ap_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
